// File: rtl/dma_ram_responder.sv
// RAM-side burst responder: one write or read burst at a time, 16-bit words, 13-bit address.
// Write accepts 1 word/cycle on wr_valid/wr_ready; read streams via a 2-entry FIFO under rd_ready backpressure.

module dma_ram_responder_fifo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push_vld,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic         o_vld,
    output logic [W-1:0] o_dat,
    output logic [1:0]   o_count
);
    // Two-entry FIFO; the caller guarantees no push when full.
    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic         w_pop;

    assign w_pop = i_pop && (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push_vld) begin
                r_mem[r_wptr] <= i_push_dat;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, i_push_vld} - {1'b0, w_pop};
        end
    end

    assign o_vld   = (r_count != 2'd0);
    assign o_dat   = r_mem[r_rptr];
    assign o_count = r_count;
endmodule

module dma_ram_responder #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    localparam logic [ADDR_W:0] MEM_DEPTH = (ADDR_W + 1)'(1) << ADDR_W;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_count;
    logic [LEN_W-1:0]  r_issue_left;
    logic              r_wr_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_inflight;
    logic [DATA_W-1:0] r_mem_q;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    logic [ADDR_W:0]   w_end;
    logic              w_oob;
    logic              w_len_zero;
    logic              w_accept_rd;
    logic              w_issue;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_wr_en;
    logic              w_fifo_vld;
    logic [DATA_W-1:0] w_fifo_dat;
    logic [1:0]        w_fifo_cnt;
    logic              w_pop;
    logic [2:0]        w_used;

    assign w_end      = {1'b0, req_addr} + {{(ADDR_W + 1 - LEN_W){1'b0}}, req_len};
    assign w_oob      = (w_end > MEM_DEPTH);
    assign w_len_zero = (req_len == '0);

    // The first read is issued on the accept edge itself so the head word is visible two cycles later.
    assign w_accept_rd = (r_state == S_IDLE) && req && !req_write && !w_len_zero && !w_oob;
    assign w_pop       = w_fifo_vld && rd_ready;
    // Slot accounting credits a same-cycle pop, which keeps the stream bubble-free at full rate.
    assign w_used      = {1'b0, w_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = w_accept_rd ||
                         ((r_state == S_READ) && (r_issue_left != '0) && (w_used < 3'd2));
    assign w_rd_addr   = (r_state == S_IDLE) ? req_addr : r_addr;
    assign w_wr_en     = !rst && (r_state == S_WRITE) && wr_valid && r_wr_ready;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_addr] <= wr_data;
        end
        if (w_issue) begin
            r_mem_q <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
        end
    end

    dma_ram_responder_fifo #(.W(DATA_W)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push_vld (r_inflight),
        .i_push_dat (r_mem_q),
        .i_pop      (w_pop),
        .o_vld      (w_fifo_vld),
        .o_dat      (w_fifo_dat),
        .o_count    (w_fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_count      <= '0;
            r_issue_left <= '0;
            r_wr_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        if (w_len_zero) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (w_oob) begin
                            r_err <= 1'b1;
                        end else begin
                            r_count <= req_len;
                            r_busy  <= 1'b1;
                            if (req_write) begin
                                r_state    <= S_WRITE;
                                r_addr     <= req_addr;
                                r_wr_ready <= 1'b1;
                            end else begin
                                r_state      <= S_READ;
                                r_addr       <= req_addr + ADDR_W'(1);
                                r_issue_left <= req_len - LEN_W'(1);
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (wr_valid) begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_count <= r_count - LEN_W'(1);
                        if (r_count == LEN_W'(1)) begin
                            r_state    <= S_DONE;
                            r_wr_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_addr       <= r_addr + ADDR_W'(1);
                        r_issue_left <= r_issue_left - LEN_W'(1);
                    end
                    if (w_pop) begin
                        r_count <= r_count - LEN_W'(1);
                        if (r_count == LEN_W'(1)) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_ready = r_wr_ready;
    assign rd_valid = w_fifo_vld;
    assign rd_data  = w_fifo_dat;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
endmodule
